// File: rtl/hazard_pkg.sv
// Shared types, constants and a parameter sanity check for the pipeline
// hazard / forwarding controller.
package hazard_pkg;

    // Widest register address the tracker entry can hold.
    localparam int REG_AW_MAX  = 8;
    // Holds BRANCH_PENALTY-1 for penalties up to 3.
    localparam int FLUSH_CNT_W = 2;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] rd;
        logic                  wr_en;
        logic                  is_load;
    } track_entry_t;

    localparam int ENTRY_W = $bits(track_entry_t);

    function automatic logic hazard_params_ok(
        input int reg_aw,
        input int track_depth,
        input int branch_penalty,
        input int cnt_w
    );
        return (reg_aw >= 1) && (reg_aw <= REG_AW_MAX) &&
               (track_depth >= 2) && (track_depth <= 4) &&
               (branch_penalty >= 1) && (branch_penalty <= 3) &&
               (cnt_w >= 1);
    endfunction

endpackage

// File: rtl/hazard_tracker.sv
// Shadow pipeline of in-flight destination registers: entry 0 is execute,
// higher entries are later stages. Advances, holds, or inserts a bubble.
module hazard_tracker
    import hazard_pkg::*;
#(
    parameter int TRACK_DEPTH = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           advance,
    input  logic                           insert_bubble,
    input  logic [ENTRY_W-1:0]             new_entry,
    output logic [TRACK_DEPTH*ENTRY_W-1:0] entries
);

    track_entry_t [TRACK_DEPTH-1:0] entries_q;
    track_entry_t [TRACK_DEPTH-1:0] entries_d;
    track_entry_t                   ins_entry;

    always_comb begin
        ins_entry = track_entry_t'(new_entry);
        if (insert_bubble) begin
            ins_entry = '0;
        end

        entries_d = entries_q;
        if (advance) begin
            entries_d[0] = ins_entry;
            for (int k = 1; k < TRACK_DEPTH; k++) begin
                entries_d[k] = entries_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entries_q <= '0;
        end else begin
            entries_q <= entries_d;
        end
    end

    assign entries = entries_q;

endmodule

// File: rtl/hazard_unit.sv
// Hazard, forwarding and stall/flush controller for the five-stage in-order
// pipeline: forwarding selects, load-use bubbles, branch flushes, memory freeze.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter  int REG_AW         = 5,
    parameter  int TRACK_DEPTH    = 3,
    parameter  int BRANCH_PENALTY = 2,
    parameter  int CNT_W          = 32,
    localparam int SEL_W          = $clog2(TRACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr_enable,
    input  logic              id_mem_to_reg,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              stall_fetch,
    output logic              stall_decode,
    output logic              bubble_execute,
    output logic              flush_decode,
    output logic              pipe_freeze,
    output logic [SEL_W-1:0]  fwd_sel_rs1,
    output logic [SEL_W-1:0]  fwd_sel_rs2,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_cycles
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(BRANCH_PENALTY - 1);

    if (!hazard_params_ok(REG_AW, TRACK_DEPTH, BRANCH_PENALTY, CNT_W)) begin : g_bad_params
        $error("hazard_unit: illegal parameter combination");
    end

    track_entry_t [TRACK_DEPTH-1:0] trk;
    logic [TRACK_DEPTH*ENTRY_W-1:0] trk_flat;
    track_entry_t                   new_entry;
    logic                           insert_bubble;

    logic [REG_AW_MAX-1:0] rs1_ext;
    logic [REG_AW_MAX-1:0] rs2_ext;
    logic [REG_AW_MAX-1:0] rd_ext;
    logic [SEL_W-1:0]      sel1;
    logic [SEL_W-1:0]      sel2;
    logic                  lu_hit;

    logic freeze;
    logic branch;
    logic flush;
    logic load_use;
    logic stall;

    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]       flush_cyc_q, flush_cyc_d;

    // True when entry e produces the register a decode source is reading.
    // exclude_load drops loads, whose data is not yet available in execute.
    function automatic logic fwd_hit(
        input track_entry_t          e,
        input logic [REG_AW_MAX-1:0] rs,
        input logic                  used,
        input logic                  exclude_load
    );
        return used && (rs != '0) && e.valid && e.wr_en && (e.rd == rs) &&
               !(exclude_load && e.is_load);
    endfunction

    hazard_tracker #(
        .TRACK_DEPTH (TRACK_DEPTH)
    ) u_tracker (
        .clk           (clk),
        .rst           (rst),
        .advance       (!freeze),
        .insert_bubble (insert_bubble),
        .new_entry     (new_entry),
        .entries       (trk_flat)
    );

    assign trk = trk_flat;

    always_comb begin
        rs1_ext = '0;
        rs2_ext = '0;
        rd_ext  = '0;
        rs1_ext[REG_AW-1:0] = id_rs1;
        rs2_ext[REG_AW-1:0] = id_rs2;
        rd_ext[REG_AW-1:0]  = id_rd;

        new_entry         = '0;
        new_entry.valid   = 1'b1;
        new_entry.rd      = rd_ext;
        new_entry.wr_en   = id_wr_enable;
        new_entry.is_load = id_mem_to_reg;
    end

    // Scan from the oldest entry down so the youngest producer wins.
    always_comb begin
        sel1 = SEL_W'(FWD_RF);
        sel2 = SEL_W'(FWD_RF);
        for (int k = TRACK_DEPTH - 1; k >= 0; k--) begin
            if (fwd_hit(trk[k], rs1_ext, id_rs1_used, k == 0)) begin
                sel1 = SEL_W'(k + 1);
            end
            if (fwd_hit(trk[k], rs2_ext, id_rs2_used, k == 0)) begin
                sel2 = SEL_W'(k + 1);
            end
        end
        lu_hit = trk[0].is_load &&
                 (fwd_hit(trk[0], rs1_ext, id_rs1_used, 1'b0) ||
                  fwd_hit(trk[0], rs2_ext, id_rs2_used, 1'b0));
    end

    // mem_req/mem_ready: a data access completes on the cycle both are high;
    // while mem_req is high and mem_ready low, every pipeline register holds.
    always_comb begin
        freeze        = rst && mem_req && !mem_ready;
        branch        = rst && ex_branch_taken && !freeze;
        flush         = branch || (!freeze && (flush_cnt_q != '0));
        load_use      = rst && id_valid && lu_hit && !flush && !freeze;
        stall         = freeze || load_use;
        insert_bubble = !id_valid || flush || load_use;
    end

    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (!freeze) begin
            if (branch) begin
                flush_cnt_d = FLUSH_RELOAD;
            end else if (flush_cnt_q != '0) begin
                flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
            end
        end

        stall_cnt_d = stall_cnt_q + CNT_W'(stall);
        flush_cyc_d = flush_cyc_q + CNT_W'(flush);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cyc_q <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cyc_q <= flush_cyc_d;
        end
    end

    assign stall_fetch    = stall;
    assign stall_decode   = stall;
    assign bubble_execute = load_use;
    assign flush_decode   = flush;
    assign pipe_freeze    = freeze;
    assign fwd_sel_rs1    = sel1;
    assign fwd_sel_rs2    = sel2;
    assign stall_cycles   = stall_cnt_q;
    assign flush_cycles   = flush_cyc_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios plus randomized traffic checked
// against an instruction-level model of the in-flight pipeline.
module tb_hazard_unit;

    localparam int REG_AW         = 5;
    localparam int TRACK_DEPTH    = 3;
    localparam int BRANCH_PENALTY = 2;
    localparam int CNT_W          = 32;
    localparam int SEL_W          = 2;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic              id_rs1_used, id_rs2_used;
    logic              id_wr_enable, id_mem_to_reg;
    logic              ex_branch_taken, mem_req, mem_ready;
    logic              stall_fetch, stall_decode, bubble_execute, flush_decode, pipe_freeze;
    logic [SEL_W-1:0]  fwd_sel_rs1, fwd_sel_rs2;
    logic [CNT_W-1:0]  stall_cycles, flush_cycles;

    always #5 clk = ~clk;

    hazard_unit #(
        .REG_AW         (REG_AW),
        .TRACK_DEPTH    (TRACK_DEPTH),
        .BRANCH_PENALTY (BRANCH_PENALTY),
        .CNT_W          (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .id_rd           (id_rd),
        .id_wr_enable    (id_wr_enable),
        .id_mem_to_reg   (id_mem_to_reg),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .stall_fetch     (stall_fetch),
        .stall_decode    (stall_decode),
        .bubble_execute  (bubble_execute),
        .flush_decode    (flush_decode),
        .pipe_freeze     (pipe_freeze),
        .fwd_sel_rs1     (fwd_sel_rs1),
        .fwd_sel_rs2     (fwd_sel_rs2),
        .stall_cycles    (stall_cycles),
        .flush_cycles    (flush_cycles)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    // In-flight instructions, youngest first: index 0 is execute.
    typedef struct {
        bit valid;
        int rd;
        bit wr;
        bit ld;
    } m_instr_t;

    m_instr_t         m_pipe[$];
    int               m_flush_left;
    logic [CNT_W-1:0] m_stall_cnt;
    logic [CNT_W-1:0] m_flush_cnt;

    function automatic bit m_freeze();
        return mem_req && !mem_ready;
    endfunction

    function automatic bit m_flush();
        return !m_freeze() && (ex_branch_taken || m_flush_left > 0);
    endfunction

    function automatic bit m_produces(int rs, bit used, int k);
        return used && rs != 0 && m_pipe[k].valid && m_pipe[k].wr && m_pipe[k].rd == rs;
    endfunction

    function automatic int m_sel(int rs, bit used);
        for (int k = 0; k < TRACK_DEPTH; k++) begin
            if (m_produces(rs, used, k) && !(k == 0 && m_pipe[0].ld)) return k + 1;
        end
        return 0;
    endfunction

    function automatic bit m_load_use();
        return id_valid && !m_freeze() && !m_flush() && m_pipe[0].ld &&
               (m_produces(int'(id_rs1), id_rs1_used, 0) || m_produces(int'(id_rs2), id_rs2_used, 0));
    endfunction

    task automatic model_reset();
        m_pipe.delete();
        for (int k = 0; k < TRACK_DEPTH; k++) m_pipe.push_back('{0, 0, 0, 0});
        m_flush_left = 0;
        m_stall_cnt  = '0;
        m_flush_cnt  = '0;
    endtask

    task automatic model_clock();
        bit       frz, fl, lu;
        m_instr_t ins;
        frz = m_freeze();
        fl  = m_flush();
        lu  = m_load_use();
        if (frz || lu) m_stall_cnt = m_stall_cnt + 1'b1;
        if (fl) m_flush_cnt = m_flush_cnt + 1'b1;
        if (!frz) begin
            if (ex_branch_taken) m_flush_left = BRANCH_PENALTY - 1;
            else if (m_flush_left > 0) m_flush_left--;
            ins.valid = id_valid && !fl && !lu;
            ins.rd    = int'(id_rd);
            ins.wr    = id_wr_enable;
            ins.ld    = id_mem_to_reg;
            m_pipe.push_front(ins);
            void'(m_pipe.pop_back());
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd = '0; id_wr_enable = 0; id_mem_to_reg = 0;
        ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic drive_dec(input bit v, input int rd, input bit wr, input bit ld,
                             input int rs1, input bit u1, input int rs2, input bit u2);
        id_valid = v; id_rd = REG_AW'(rd); id_wr_enable = wr; id_mem_to_reg = ld;
        id_rs1 = REG_AW'(rs1); id_rs1_used = u1; id_rs2 = REG_AW'(rs2); id_rs2_used = u2;
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 0;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 0;
        idle_inputs();
        model_reset();
        id_valid = 1; mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({stall_fetch, stall_decode, bubble_execute, flush_decode, pipe_freeze} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b expected 00000",
                     {stall_fetch, stall_decode, bubble_execute, flush_decode, pipe_freeze});
        end
        n_checks++;
        if ({fwd_sel_rs1, fwd_sel_rs2, stall_cycles, flush_cycles} !== '0) begin
            n_fail++;
            $display("FAIL reset_data fwd %0d/%0d cnt %0d/%0d expected all 0",
                     fwd_sel_rs1, fwd_sel_rs2, stall_cycles, flush_cycles);
        end
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1;
        #1;
        n_checks++;
        if ({stall_decode, flush_decode, pipe_freeze} !== 3'b0) begin
            n_fail++;
            $display("FAIL reset_release got %b expected 000", {stall_decode, flush_decode, pipe_freeze});
        end
    endtask

    task automatic test_forwarding();
        apply_reset();
        drive_dec(1, 5, 1, 0, 0, 0, 0, 0);          // addi x5
        #1; tick();
        drive_dec(1, 6, 1, 0, 5, 1, 5, 1);          // add x6, x5, x5
        #1;
        n_checks++;
        if ({fwd_sel_rs1, fwd_sel_rs2} !== {2'd1, 2'd1}) begin
            n_fail++;
            $display("FAIL fwd_ex got %0d/%0d expected 1/1", fwd_sel_rs1, fwd_sel_rs2);
        end
        n_checks++;
        if ({stall_decode, bubble_execute, flush_decode} !== 3'b0) begin
            n_fail++;
            $display("FAIL fwd_ex_nostall got %b expected 000", {stall_decode, bubble_execute, flush_decode});
        end
        tick();
        drive_dec(1, 7, 1, 0, 5, 1, 5, 0);          // x5 now in memory; rs2 unused
        #1;
        n_checks++;
        if ({fwd_sel_rs1, fwd_sel_rs2} !== {2'd2, 2'd0}) begin
            n_fail++;
            $display("FAIL fwd_mem got %0d/%0d expected 2/0", fwd_sel_rs1, fwd_sel_rs2);
        end
        tick();
        drive_dec(1, 0, 0, 0, 0, 0, 5, 1);          // x5 now in writeback
        #1;
        n_checks++;
        if ({fwd_sel_rs1, fwd_sel_rs2} !== {2'd0, 2'd3}) begin
            n_fail++;
            $display("FAIL fwd_wb got %0d/%0d expected 0/3", fwd_sel_rs1, fwd_sel_rs2);
        end
        tick();
    endtask

    task automatic test_load_use();
        apply_reset();
        drive_dec(1, 7, 1, 1, 0, 0, 0, 0);          // lw x7
        #1; tick();
        drive_dec(1, 8, 1, 0, 7, 1, 0, 0);          // add x8, x7
        #1;
        n_checks++;
        if ({stall_fetch, stall_decode, bubble_execute, flush_decode, pipe_freeze} !== 5'b11100) begin
            n_fail++;
            $display("FAIL load_use_stall got %b expected 11100",
                     {stall_fetch, stall_decode, bubble_execute, flush_decode, pipe_freeze});
        end
        n_checks++;
        if (fwd_sel_rs1 !== 2'd0) begin
            n_fail++;
            $display("FAIL load_use_nofwd got %0d expected 0", fwd_sel_rs1);
        end
        tick();
        #1;
        n_checks++;
        if ({stall_fetch, stall_decode, bubble_execute} !== 3'b000 || fwd_sel_rs1 !== 2'd2) begin
            n_fail++;
            $display("FAIL load_use_after got stall %b fwd %0d expected 000 and 2",
                     {stall_fetch, stall_decode, bubble_execute}, fwd_sel_rs1);
        end
        n_checks++;
        if (stall_cycles !== 32'd1) begin
            n_fail++;
            $display("FAIL load_use_count got %0d expected 1", stall_cycles);
        end
        tick();
    endtask

    task automatic test_branch_flush();
        apply_reset();
        ex_branch_taken = 1;
        drive_dec(1, 9, 1, 0, 0, 0, 0, 0);          // squashed writer x9
        #1;
        n_checks++;
        if ({stall_decode, bubble_execute, flush_decode, pipe_freeze} !== 4'b0010) begin
            n_fail++;
            $display("FAIL flush_c0 got %b expected 0010",
                     {stall_decode, bubble_execute, flush_decode, pipe_freeze});
        end
        tick();
        ex_branch_taken = 0;
        #1;
        n_checks++;
        if (flush_decode !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_c1 got %b expected 1", flush_decode);
        end
        tick();
        drive_dec(1, 10, 1, 0, 9, 1, 9, 1);         // reads x9
        #1;
        n_checks++;
        if ({flush_decode, fwd_sel_rs1, fwd_sel_rs2} !== 5'b0) begin
            n_fail++;
            $display("FAIL flush_end got flush %b fwd %0d/%0d expected 0 0/0",
                     flush_decode, fwd_sel_rs1, fwd_sel_rs2);
        end
        n_checks++;
        if (flush_cycles !== 32'd2) begin
            n_fail++;
            $display("FAIL flush_count got %0d expected 2", flush_cycles);
        end
        tick();
        // second branch arriving mid-flush reloads the squash window
        idle_inputs();
        ex_branch_taken = 1;
        #1; tick();
        #1; tick();
        ex_branch_taken = 0;
        #1;
        n_checks++;
        if (flush_decode !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_reload got %b expected 1", flush_decode);
        end
        tick();
        #1;
        n_checks++;
        if (flush_decode !== 1'b0 || flush_cycles !== 32'd5) begin
            n_fail++;
            $display("FAIL flush_reload_end got flush %b count %0d expected 0 and 5", flush_decode, flush_cycles);
        end
        tick();
    endtask

    task automatic test_freeze();
        apply_reset();
        drive_dec(1, 11, 1, 0, 0, 0, 0, 0);         // writer x11
        #1; tick();
        idle_inputs();
        #1; tick();
        drive_dec(1, 12, 1, 0, 11, 1, 0, 0);        // reader x11 (entry 1)
        mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if ({stall_fetch, stall_decode, bubble_execute, flush_decode, pipe_freeze} !== 5'b11001 ||
                fwd_sel_rs1 !== 2'd2) begin
                n_fail++;
                $display("FAIL freeze_c%0d got %b fwd %0d expected 11001 fwd 2", c,
                         {stall_fetch, stall_decode, bubble_execute, flush_decode, pipe_freeze}, fwd_sel_rs1);
            end
            tick();
        end
        mem_ready = 1;
        #1;
        n_checks++;
        if ({stall_decode, flush_decode, pipe_freeze} !== 3'b010 || fwd_sel_rs1 !== 2'd2 ||
            stall_cycles !== 32'd3) begin
            n_fail++;
            $display("FAIL freeze_release got %b fwd %0d stalls %0d expected 010 fwd 2 stalls 3",
                     {stall_decode, flush_decode, pipe_freeze}, fwd_sel_rs1, stall_cycles);
        end
        tick();
        mem_req = 0; mem_ready = 0; ex_branch_taken = 0;
        #1;
        n_checks++;
        if (fwd_sel_rs1 !== 2'd3 || flush_decode !== 1'b1) begin
            n_fail++;
            $display("FAIL freeze_advance got fwd %0d flush %b expected 3 and 1", fwd_sel_rs1, flush_decode);
        end
        tick();
    endtask

    task automatic test_x0_and_youngest();
        apply_reset();
        drive_dec(1, 0, 1, 0, 0, 0, 0, 0);          // writes x0
        #1; tick();
        drive_dec(1, 13, 1, 0, 0, 1, 0, 1);         // reads x0, x0; writes x13
        #1;
        n_checks++;
        if ({fwd_sel_rs1, fwd_sel_rs2} !== 4'b0) begin
            n_fail++;
            $display("FAIL x0_fwd got %0d/%0d expected 0/0", fwd_sel_rs1, fwd_sel_rs2);
        end
        tick();
        drive_dec(1, 14, 1, 0, 0, 0, 0, 0);         // writes x14
        #1; tick();
        drive_dec(1, 13, 1, 0, 0, 0, 0, 0);         // writes x13 again
        #1; tick();
        drive_dec(1, 15, 1, 0, 13, 1, 14, 1);       // x13 in entries 0 and 2
        #1;
        n_checks++;
        if ({fwd_sel_rs1, fwd_sel_rs2} !== {2'd1, 2'd2}) begin
            n_fail++;
            $display("FAIL youngest_fwd got %0d/%0d expected 1/2", fwd_sel_rs1, fwd_sel_rs2);
        end
        tick();
    endtask

    task automatic test_reset_mid_flush();
        apply_reset();
        ex_branch_taken = 1;
        #1; tick();
        ex_branch_taken = 0;
        #1;
        n_checks++;
        if (flush_decode !== 1'b1 || flush_cycles !== 32'd1) begin
            n_fail++;
            $display("FAIL midflush_pre got flush %b count %0d expected 1 and 1", flush_decode, flush_cycles);
        end
        rst = 0;
        #1;
        n_checks++;
        if ({stall_fetch, stall_decode, bubble_execute, flush_decode, pipe_freeze,
             fwd_sel_rs1, fwd_sel_rs2, stall_cycles, flush_cycles} !== '0) begin
            n_fail++;
            $display("FAIL midflush_reset got ctrl %b cnt %0d/%0d expected all 0",
                     {stall_fetch, stall_decode, bubble_execute, flush_decode, pipe_freeze},
                     stall_cycles, flush_cycles);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1;
        #1;
        n_checks++;
        if (flush_decode !== 1'b0) begin
            n_fail++;
            $display("FAIL midflush_release got %b expected 0", flush_decode);
        end
        tick();
        #1;
        n_checks++;
        if (flush_decode !== 1'b0 || flush_cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL midflush_after got flush %b count %0d expected 0 and 0", flush_decode, flush_cycles);
        end
    endtask

    task automatic test_random();
        logic [8:0] exp_q[$];
        logic [8:0] exp_w;
        logic [8:0] got_w;
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            id_valid        = ($urandom_range(0, 3) != 0);
            id_rs1          = REG_AW'($urandom_range(0, 6));
            id_rs2          = REG_AW'($urandom_range(0, 6));
            id_rs1_used     = 1'($urandom_range(0, 1));
            id_rs2_used     = 1'($urandom_range(0, 1));
            id_rd           = REG_AW'($urandom_range(0, 6));
            id_wr_enable    = ($urandom_range(0, 3) != 0);
            id_mem_to_reg   = ($urandom_range(0, 2) == 0);
            ex_branch_taken = ($urandom_range(0, 9) == 0);
            mem_req         = ($urandom_range(0, 2) == 0);
            mem_ready       = 1'($urandom_range(0, 1));
            #1;
            exp_q.push_back({m_freeze() || m_load_use(), m_freeze() || m_load_use(), m_load_use(),
                             m_flush(), m_freeze(),
                             SEL_W'(m_sel(int'(id_rs1), id_rs1_used)),
                             SEL_W'(m_sel(int'(id_rs2), id_rs2_used))});
            exp_w = exp_q.pop_front();
            got_w = {stall_fetch, stall_decode, bubble_execute, flush_decode, pipe_freeze,
                     fwd_sel_rs1, fwd_sel_rs2};
            n_checks++;
            if (got_w !== exp_w) begin
                n_fail++;
                $display("FAIL rand_ctrl cycle %0d got %b expected %b", c, got_w, exp_w);
            end
            n_checks++;
            if (stall_cycles !== m_stall_cnt || flush_cycles !== m_flush_cnt) begin
                n_fail++;
                $display("FAIL rand_counters cycle %0d got %0d/%0d expected %0d/%0d",
                         c, stall_cycles, flush_cycles, m_stall_cnt, m_flush_cnt);
            end
            tick();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 0;
        idle_inputs();
        model_reset();
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_flush();
        test_freeze();
        test_x0_and_youngest();
        test_reset_mid_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1, "watchdog");
    end

endmodule
